// File: rtl/nn_mem_pkg.sv
// Shared weight-RAM layout for the read and write drivers: geometry,
// index widths, FSM state encoding and the (layer, unit, widx) -> address map.
package nn_mem_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 10;
  localparam int LAYERS    = 4;
  localparam int UNITS     = 4;
  localparam int WEIGHTS   = 4;
  localparam int BASE_ADDR = 0;

  localparam int LAYER_W = (LAYERS  > 1) ? $clog2(LAYERS)  : 1;
  localparam int UNIT_W  = (UNITS   > 1) ? $clog2(UNITS)   : 1;
  localparam int WIDX_W  = (WEIGHTS > 1) ? $clog2(WEIGHTS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_FINISH  = 3'd3,
    ST_ABORT   = 3'd4
  } wr_state_e;

  // Layer-major, then unit, then weight index; both drivers must use this.
  function automatic int unsigned ram_addr_of(
    input int unsigned layer_idx,
    input int unsigned unit_idx,
    input int unsigned widx,
    input int unsigned units   = UNITS,
    input int unsigned weights = WEIGHTS,
    input int unsigned base    = BASE_ADDR
  );
    return base + (layer_idx * units + unit_idx) * weights + widx;
  endfunction

endpackage

// File: rtl/ram_write_driver_byte_packer.sv
// Packs a byte stream little-endian into DATA_W-bit words; word_valid pulses
// combinationally with the last byte so the caller can register the word.
module byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  localparam int BYTES = DATA_W / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] acc;
  logic [CW-1:0]     cnt;

  assign word_valid = take && (cnt == CW'(BYTES - 1));

  // The final byte bypasses the accumulator straight into the top lane.
  always_comb begin
    word                 = acc;
    word[DATA_W-1 -: 8]  = byte_in;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc[8*cnt +: 8] <= byte_in;
      cnt             <= word_valid ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ram_write_driver.sv
// Loads weight words into the weight RAM from a byte stream, one layer or all
// layers, using the shared layer/unit/weight address layout.
module ram_write_driver #(
  parameter int DATA_W    = nn_mem_pkg::DATA_W,
  parameter int ADDR_W    = nn_mem_pkg::ADDR_W,
  parameter int LAYERS    = nn_mem_pkg::LAYERS,
  parameter int UNITS     = nn_mem_pkg::UNITS,
  parameter int WEIGHTS   = nn_mem_pkg::WEIGHTS,
  parameter int BASE_ADDR = nn_mem_pkg::BASE_ADDR,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              single_layer,
  input  logic [1:0]        layer_sel,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import nn_mem_pkg::*;

  localparam int LW = (LAYERS  > 1) ? $clog2(LAYERS)  : 1;
  localparam int UW = (UNITS   > 1) ? $clog2(UNITS)   : 1;
  localparam int WW = (WEIGHTS > 1) ? $clog2(WEIGHTS) : 1;
  localparam int IW = LW + UW + WW;
  localparam int TW = 16;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  wr_state_e         state;
  logic [IW-1:0]     idx;
  logic              single;
  logic [TW-1:0]     idle_cnt;
  logic              take;
  logic              pk_clear;
  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic              last_word;
  logic [ADDR_W-1:0] addr_now;

  logic [LW-1:0] layer_idx;
  logic [UW-1:0] unit_idx;
  logic [WW-1:0] widx;

  assign layer_idx = idx[IW-1 -: LW];
  assign unit_idx  = idx[WW +: UW];
  assign widx      = idx[WW-1:0];

  assign take     = byte_valid && byte_ready;
  assign pk_clear = (state != ST_COLLECT);

  assign last_word = (widx == WW'(WEIGHTS - 1)) && (unit_idx == UW'(UNITS - 1)) &&
                     (single || (layer_idx == LW'(LAYERS - 1)));

  assign addr_now = ADDR_W'(ram_addr_of(32'(layer_idx), 32'(unit_idx), 32'(widx),
                                        UNITS, WEIGHTS, BASE_ADDR));

  byte_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .take      (take),
    .byte_in   (byte_in),
    .word      (word),
    .word_valid(word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      single     <= 1'b0;
      idle_cnt   <= '0;
      byte_ready <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            single     <= single_layer;
            idx        <= single_layer ? {LW'(layer_sel), (UW + WW)'(0)} : '0;
            idle_cnt   <= '0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
            state      <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (word_valid) begin
            state      <= ST_WRITE;
            byte_ready <= 1'b0;
            idle_cnt   <= '0;
            ram_we     <= 1'b1;
            ram_din    <= word;
            ram_addr   <= addr_now;
          end else if (take) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TO_LAST) begin
            // Stream stalled too long: give up; the packer drops the partial word.
            state      <= ST_ABORT;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        ST_WRITE: begin
          if (last_word) begin
            state <= ST_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // Power-of-two geometry lets the nested index be one binary counter.
            idx        <= idx + IW'(1);
            idle_cnt   <= '0;
            byte_ready <= 1'b1;
            state      <= ST_COLLECT;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        ST_ABORT:  state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_write_driver.sv
// Randomised byte-stream bench for ram_write_driver with a queue-based write model.
module tb_ram_write_driver;

  localparam int UNITS   = 4;
  localparam int WEIGHTS = 4;
  localparam int LAYERS  = 4;
  localparam int TO      = 20;

  logic        clk = 1'b0;
  logic        reset, start, single_layer, byte_valid;
  logic [1:0]  layer_sel;
  logic [7:0]  byte_in;
  logic        byte_ready, ram_we, busy, done, err;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;

  always #5 clk = ~clk;

  ram_write_driver #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .single_layer(single_layer),
    .layer_sel(layer_sel), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  stream [0:255];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_count, done_cnt, err_cnt;
  logic [9:0]  first_addr, last_addr;
  logic [31:0] first_data, last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Every write the DUT issues must be the next one the model predicts.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wr_count == 0) begin
        first_addr = ram_addr;
        first_data = ram_din;
      end
      last_addr = ram_addr;
      last_data = ram_din;
      wr_count++;
      chk("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", {54'd0, ram_addr}, {54'd0, e.a});
        chk("write_data", {32'd0, ram_din}, {32'd0, e.d});
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_after_last_write", 64'(exp_q.size()), 64'd0);
    end
    if (err === 1'b1) err_cnt++;
  end

  task automatic clear_stats();
    wr_count = 0;
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Builds the stream, predicts the writes for every complete word, then feeds it.
  task automatic load(input bit single, input int lsel, input int nbytes,
                      input int gap_max, input int glitch_at, input bit inc_pattern);
    int base;
    for (int i = 0; i < nbytes; i++)
      stream[i] = inc_pattern ? 8'(i) : 8'($urandom_range(0, 255));
    base = single ? lsel * UNITS * WEIGHTS : 0;
    for (int w = 0; w < nbytes / 4; w++) begin
      wr_t e;
      e.a = 10'(base + w);
      e.d = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
      exp_q.push_back(e);
    end
    @(negedge clk);
    single_layer = single;
    layer_sel    = 2'(lsel);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    single_layer = 1'b0;
    layer_sel    = 2'd0;
    for (int i = 0; i < nbytes; i++) begin
      int g;
      int cyc;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) @(negedge clk);
      byte_in    = stream[i];
      byte_valid = 1'b1;
      if (i == glitch_at) begin
        start        = 1'b1;
        single_layer = 1'b1;
        layer_sel    = 2'd3;
      end
      cyc = 0;
      while (byte_ready !== 1'b1 && cyc < 50) begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
      if (cyc >= 50) begin
        chk("byte_ready_wait", 64'd0, 64'd1);
        byte_valid = 1'b0;
        return;
      end
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_low_after", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_outs"}, {50'd0, byte_ready, ram_addr, ram_we, busy, done, err},
        64'd0);
    chk({tag, "_din"}, {32'd0, ram_din}, 64'd0);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; single_layer = 1'b0; layer_sel = 2'd0;
    byte_in = 8'd0; byte_valid = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single layer 2, incrementing bytes, no gaps.
    clear_stats();
    load(1'b1, 2, 64, 0, -1, 1'b1);
    wait_done();
    chk("single_count", 64'(wr_count), 64'd16);
    chk("single_first_addr", {54'd0, first_addr}, 64'd32);
    chk("single_first_data", {32'd0, first_data}, 64'h03020100);
    chk("single_last_addr", {54'd0, last_addr}, 64'd47);
    chk("single_last_data", {32'd0, last_data}, 64'h3F3E3D3C);
    chk("single_done_cnt", 64'(done_cnt), 64'd1);

    // Same stream with random valid gaps must produce the same words.
    clear_stats();
    load(1'b1, 2, 64, 6, -1, 1'b1);
    wait_done();
    chk("gap_count", 64'(wr_count), 64'd16);
    chk("gap_last_data", {32'd0, last_data}, 64'h3F3E3D3C);

    // Full load, random data.
    clear_stats();
    load(1'b0, 0, 256, 0, -1, 1'b0);
    wait_done();
    chk("full_count", 64'(wr_count), 64'd64);
    chk("full_last_addr", {54'd0, last_addr}, 64'd63);
    chk("full_no_err", 64'(err_cnt), 64'd0);

    // Random mode, layer and gaps.
    for (int r = 0; r < 2; r++) begin
      bit s;
      int ls;
      s  = 1'($urandom_range(0, 1));
      ls = $urandom_range(0, 3);
      clear_stats();
      load(s, ls, s ? 64 : 256, 5, -1, 1'b0);
      wait_done();
      chk("rand_count", 64'(wr_count), s ? 64'd16 : 64'(LAYERS * 16));
    end

    // Timeout: 6 bytes then silence.
    clear_stats();
    load(1'b0, 0, 6, 0, -1, 1'b1);
    k = 1;
    while (k <= 40) begin
      @(posedge clk);
      #1;
      if (err === 1'b1) break;
      k++;
    end
    chk("timeout_cycles", 64'(k), 64'(TO));
    chk("timeout_busy_low", {63'd0, busy}, 64'd0);
    chk("timeout_writes", 64'(wr_count), 64'd1);
    chk("timeout_first_data", {32'd0, first_data}, 64'h03020100);
    @(posedge clk);
    #1;
    chk("err_one_cycle", {63'd0, err}, 64'd0);
    chk("busy_stays_low", {63'd0, busy}, 64'd0);

    // Reset 10 bytes into a load.
    clear_stats();
    load(1'b0, 0, 10, 0, -1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    exp_q.delete();
    reset = 1'b0;
    wr_count = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("postreset");
    chk("no_write_after_reset", 64'(wr_count), 64'd0);

    // Reset beats start in the same cycle.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_lost_to_reset", {63'd0, busy}, 64'd0);

    // Full reload from addr 0 with a stray start mid-stream.
    clear_stats();
    load(1'b0, 0, 256, 2, 50, 1'b0);
    wait_done();
    chk("reload_first_addr", {54'd0, first_addr}, 64'd0);
    chk("reload_count", 64'(wr_count), 64'd64);
    chk("reload_last_addr", {54'd0, last_addr}, 64'd63);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ram_write_driver.md
Name: ram_write_driver

Overview:
- Write-side counterpart of the weight RAM read path. It accepts a byte stream over a valid/ready handshake and packs every 4 bytes into one 32-bit weight word.
- It writes each word into the weight RAM (10-bit address, 32-bit data) using the same layer/unit/weight-index layout the read driver walks.
- It sits between the host byte source (UART or ROM loader) and the RAM port, and loads one layer or all layers before the network controller is started.

Parameters:
- DATA_W, 32, RAM word width
- ADDR_W, 10, RAM address width
- LAYERS, 4, number of layers (power of 2)
- UNITS, 4, neural units per layer (power of 2)
- WEIGHTS, 4, weight words per unit (power of 2)
- BASE_ADDR, 0, RAM address of layer 0 / unit 0 / weight 0
- TIMEOUT, 1000, idle cycles allowed mid-load before abort (max 65535)

Ports:
- clk  in  1  system clock (clk_wiz output)
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a load; ignored while busy
- single_layer  in  1  sampled at start: 1 = load only layer_sel, 0 = load layers 0..LAYERS-1
- layer_sel  in  2  layer to load when single_layer=1, sampled at start
- byte_in  in  8  stream data
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  driver can accept a byte
- ram_addr  out  ADDR_W  RAM write address
- ram_din  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable, one cycle per word
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load complete
- err  out  1  one-cycle pulse, load aborted on timeout

Behaviour:
- Reset values: byte_ready=0, ram_addr=0, ram_din=0, ram_we=0, busy=0, done=0, err=0. Reset clears the state, indices, byte counter, timeout counter and partial word.
- States: IDLE, COLLECT, WRITE, FINISH, ABORT.
- IDLE:
  - On start=1, latch single_layer and layer_sel.
  - Set the layer index to layer_sel (single) or 0 (all). Clear the unit index, weight index and byte count.
  - Go to COLLECT. busy=1 from the next cycle.
- COLLECT:
  - byte_ready=1.
  - A byte transfers only when byte_valid && byte_ready. Byte k (k=0..3) goes into shift bits [8k+7:8k], so the word is little-endian.
  - The 4th transfer goes to WRITE. byte_ready is 0 in every state other than COLLECT.
- WRITE (exactly one cycle):
  - ram_we=1, ram_din = assembled word.
  - ram_addr = BASE_ADDR + {layer, unit, widx}, zero-extended to ADDR_W.
  - Indices advance as a nested counter: widx fastest, then unit, then layer.
  - The last word is widx=WEIGHTS-1 and unit=UNITS-1, with either single_layer set or layer=LAYERS-1. On the last word go to FINISH; otherwise return to COLLECT with the byte count at 0.
  - Throughput: at most one word per 5 cycles (4 byte cycles plus 1 write cycle).
- FINISH: done=1 for one cycle, busy drops to 0 in the same cycle, then IDLE.
- Timeout:
  - In COLLECT, the counter increments each cycle with no transfer and clears on every transfer.
  - When it reaches TIMEOUT, go to ABORT and discard the partial word.
- ABORT: err=1 for one cycle, busy=0, then IDLE. Words already written stay in RAM.
- Start handling: start during busy is ignored. start in the same cycle as reset loses to reset.
- Reset mid-operation (including in WRITE): takes effect at that edge, so no further ram_we is issued.
- Full-load word count:
  - Full load: LAYERS*UNITS*WEIGHTS words, which is 64 words / 256 bytes with the defaults.
  - Single-layer load: UNITS*WEIGHTS words, which is 16 words.
- ram_addr and ram_din hold their last values outside WRITE. Only ram_we qualifies them.

Decomposition:
- Shared package `nn_mem_pkg`:
  - Constants: LAYERS, UNITS, WEIGHTS, DATA_W, ADDR_W, BASE_ADDR.
  - Index widths: clog2 of each count.
  - A function that forms the RAM address from (layer, unit, widx), also used by the read driver so both ends agree on the layout.
  - The state-encoding typedef.
- One sub-module, `byte_packer`: 4-byte to 32-bit shift/assemble with a byte counter and a word_valid pulse. The FSM, index counters and timeout stay in the top.

Test Plan:
- Single layer:
  - Stimulus: reset, then start with single_layer=1, layer_sel=2, then 64 bytes 0x00..0x3F back-to-back.
  - Response: 16 ram_we pulses at addresses 32..47. The first word is 0x03020100 at addr 32 and the last is 0x3F3E3D3C at addr 47. done pulses once, then busy=0.
- Full load:
  - Stimulus: start with single_layer=0, 256 bytes.
  - Response: 64 writes at addresses 0..63 in ascending order, done after the write to addr 63, no err.
- Backpressure gaps:
  - Stimulus: byte_valid toggled 1-0-0-1 randomly with gaps shorter than TIMEOUT.
  - Response: word data identical to the gap-free run; byte_ready stays 0 during every WRITE cycle.
- Timeout:
  - Stimulus: TIMEOUT=20; send 6 bytes, then hold byte_valid=0.
  - Response: exactly 1 write (addr 0). err pulses after 20 idle cycles, and busy=0 on the following cycle.
- Reset and start corner cases:
  - Stimulus: reset asserted after 10 bytes of a load; afterwards start asserted again while busy.
  - Response: after reset all outputs are 0 and no ram_we is issued. A new start then reloads from addr 0, and a start pulse during busy does not restart the indices.
